// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and helpers for the reset sequencer
package reset_seq_pkg;

    localparam int MAX_DOMAINS = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } seq_state_e;

    // One-hot of the lowest set bit; zero in gives zero out.
    function automatic logic [MAX_DOMAINS-1:0] lowest_set_onehot(input logic [MAX_DOMAINS-1:0] v);
        return v & (~v + MAX_DOMAINS'(1));
    endfunction

endpackage

// File: rtl/reset_seq_counter.sv
// rtl/reset_seq_counter.sv - loadable down-counter that parks at zero
module reset_seq_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority; otherwise count down and stick at zero.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered assert/hold/release of per-domain resets
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [NUM_DOMAINS-1:0] req_mask,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   busy,
    output logic                   done
);

    localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_VAL  = CNT_W'(GAP_CYCLES - 1);

    seq_state_e state;
    seq_state_e state_next;

    logic [NUM_DOMAINS-1:0] pending;
    logic [MAX_DOMAINS-1:0] pending_ext;
    logic [MAX_DOMAINS-1:0] low_full;
    logic [NUM_DOMAINS-1:0] lowest;
    logic                   more_left;

    logic             cnt_load;
    logic [CNT_W-1:0] cnt_load_val;
    logic             cnt_zero;
    logic             accept;
    logic             release_now;
    logic             done_next;

    assign pending_ext = MAX_DOMAINS'(pending);
    assign low_full    = lowest_set_onehot(pending_ext);
    assign lowest      = low_full[NUM_DOMAINS-1:0];
    assign more_left   = |(pending_ext & ~low_full);

    reset_seq_counter #(
        .CNT_W(CNT_W)
    ) u_counter (
        .clk      (clk),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .zero     (cnt_zero)
    );

    // State register; reset always restarts the sequence in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_HOLD;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus counter reload and release/accept strobes.
    always_comb begin
        state_next   = state;
        cnt_load     = 1'b0;
        cnt_load_val = HOLD_VAL;
        accept       = 1'b0;
        release_now  = 1'b0;
        done_next    = 1'b0;
        if (rst) begin
            cnt_load = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        accept = 1'b1;
                        if (|req_mask) begin
                            state_next = S_HOLD;
                            cnt_load   = 1'b1;
                        end else begin
                            state_next = S_DONE;
                            done_next  = 1'b1;
                        end
                    end
                end
                S_HOLD, S_GAP: begin
                    if (cnt_zero) begin
                        release_now = 1'b1;
                        if (more_left) begin
                            state_next   = S_GAP;
                            cnt_load     = 1'b1;
                            cnt_load_val = GAP_VAL;
                        end else begin
                            state_next = S_DONE;
                            done_next  = 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

    // Handshake and activity flags decode directly from state.
    always_comb begin
        req_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
    end

    // Domain resets, pending set and done pulse; only masked bits ever move.
    always_ff @(posedge clk) begin
        if (rst) begin
            domain_rst <= '1;
            pending    <= '1;
            done       <= 1'b0;
        end else begin
            done <= done_next;
            if (accept && (|req_mask)) begin
                domain_rst <= domain_rst | req_mask;
                pending    <= req_mask;
            end else if (release_now) begin
                domain_rst <= domain_rst & ~lowest;
                pending    <= pending & ~lowest;
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - self-checking bench for reset_sequencer
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [3:0] req_mask = 4'b0;
    logic [3:0] domain_rst;
    logic       busy;
    logic       done;

    logic       req_valid_b = 1'b0;
    logic       req_ready_b;
    logic [1:0] req_mask_b = 2'b0;
    logic [1:0] domain_rst_b;
    logic       busy_b;
    logic       done_b;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int          hold_c [2] = '{8, 1};
    int          gap_c  [2] = '{4, 1};
    logic [15:0] full   [2] = '{16'h000F, 16'h0003};

    int          m_e0   [2] = '{0, 0};
    logic [15:0] m_mask [2] = '{16'h000F, 16'h0003};
    logic [15:0] m_base [2] = '{16'h0, 16'h0};
    logic [15:0] m_prev [2] = '{16'h000F, 16'h0003};
    logic        acc_last [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    reset_sequencer u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mask   (req_mask),
        .domain_rst (domain_rst),
        .busy       (busy),
        .done       (done)
    );

    reset_sequencer #(
        .NUM_DOMAINS (2),
        .HOLD_CYCLES (1),
        .GAP_CYCLES  (1)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid_b),
        .req_ready  (req_ready_b),
        .req_mask   (req_mask_b),
        .domain_rst (domain_rst_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    // Schedule model: k-th selected domain releases at e0 + HOLD + k*GAP.
    function automatic void model_eval(input int d, input int n,
                                       output logic [15:0] e_rst,
                                       output logic e_busy, output logic e_done);
        int k;
        int r;
        int last;
        k     = 0;
        last  = m_e0[d];
        e_rst = m_base[d];
        for (int i = 0; i < 16; i++) begin
            if (m_mask[d][i]) begin
                r        = m_e0[d] + hold_c[d] + k * gap_c[d];
                e_rst[i] = (n < r);
                last     = r;
                k++;
            end
        end
        e_busy = (n >= m_e0[d]) && (n <= last);
        e_done = (n == last);
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic tick();
        logic [15:0] er;
        logic        eb;
        logic        ed;
        logic        vin;
        logic        rst_pre;
        logic        pre_ok [2];
        logic [15:0] min    [2];
        rst_pre = rst;
        min[0]  = {12'b0, req_mask};
        min[1]  = {14'b0, req_mask_b};
        for (int d = 0; d < 2; d++) begin
            model_eval(d, cyc, er, eb, ed);
            vin       = (d == 0) ? req_valid : req_valid_b;
            pre_ok[d] = vin && !eb && !rst_pre;
        end
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            acc_last[d] = pre_ok[d];
            if (rst_pre) begin
                m_mask[d] = full[d];
                m_e0[d]   = cyc;
                m_base[d] = 16'h0;
            end else if (pre_ok[d]) begin
                m_base[d] = m_prev[d] & ~min[d];
                m_mask[d] = min[d];
                m_e0[d]   = cyc;
            end
            model_eval(d, cyc, er, eb, ed);
            m_prev[d] = er;
            if (d == 0) begin
                chk("a_domain_rst", {12'b0, domain_rst}, er);
                chk("a_busy",       {15'b0, busy},       {15'b0, eb});
                chk("a_done",       {15'b0, done},       {15'b0, ed});
                chk("a_req_ready",  {15'b0, req_ready},  {15'b0, !eb});
            end else begin
                chk("b_domain_rst", {14'b0, domain_rst_b}, er);
                chk("b_busy",       {15'b0, busy_b},       {15'b0, eb});
                chk("b_done",       {15'b0, done_b},       {15'b0, ed});
                chk("b_req_ready",  {15'b0, req_ready_b},  {15'b0, !eb});
            end
        end
    endtask

    task automatic wait_idle();
        logic [15:0] er;
        logic        eb0;
        logic        eb1;
        logic        ed;
        for (int i = 0; i < 80; i++) begin
            model_eval(0, cyc, er, eb0, ed);
            model_eval(1, cyc, er, eb1, ed);
            if (!eb0 && !eb1) break;
            tick();
        end
        chk("idle_a_ready", {15'b0, req_ready},   16'h1);
        chk("idle_b_ready", {15'b0, req_ready_b}, 16'h1);
    endtask

    task automatic handshake_a(input logic [3:0] m);
        req_valid = 1'b1;
        req_mask  = m;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        // Power-on reset, three edges, then full post-reset sequence.
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        wait_idle();

        // Masked sequence on bits 1 and 3.
        handshake_a(4'b1010);
        wait_idle();

        // Empty mask: immediate done, no domain change.
        handshake_a(4'b0000);
        wait_idle();

        // Request held while busy must wait for IDLE.
        handshake_a(4'b0110);
        req_valid = 1'b1;
        req_mask  = 4'b0001;
        for (int i = 0; i < 60 && req_valid; i++) begin
            tick();
            if (acc_last[0]) req_valid = 1'b0;
        end
        if (req_valid) begin
            errors++;
            $display("FAIL held_request not accepted within bound");
            req_valid = 1'b0;
        end
        wait_idle();

        // Reset ten edges into a sequence aborts it and restarts everything.
        handshake_a(4'b1010);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_idle();

        // Minimum timing instance, both domains.
        req_valid_b = 1'b1;
        req_mask_b  = 2'b11;
        tick();
        req_valid_b = 1'b0;
        wait_idle();

        // Random traffic on both instances with occasional resets.
        for (int it = 0; it < 600; it++) begin
            if (!req_valid && ($urandom % 3 == 0)) begin
                req_valid = 1'b1;
                req_mask  = 4'($urandom_range(0, 15));
            end
            if (!req_valid_b && ($urandom % 3 == 0)) begin
                req_valid_b = 1'b1;
                req_mask_b  = 2'($urandom_range(0, 3));
            end
            rst = ($urandom % 50 == 0);
            tick();
            if (acc_last[0]) req_valid = 1'b0;
            if (acc_last[1]) req_valid_b = 1'b0;
        end
        rst         = 1'b0;
        req_valid   = 1'b0;
        req_valid_b = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sequences synchronous-reset assertion and ordered deassertion for up to NUM_DOMAINS downstream domains. Those domains are built from reset-able flops with per-bit reset values.
- On global reset, and on a software request, it asserts the selected domain resets and holds them for HOLD_CYCLES.
- It then releases the domains one at a time, lowest index first, with GAP_CYCLES between releases, and signals completion.
- Sits between the top-level reset and the tile/uncore reset fan-out.

Parameters:
- NUM_DOMAINS, 4, number of controlled reset domains (1..16).
- HOLD_CYCLES, 8, cycles all selected domains are held in reset before the first release (>=1).
- GAP_CYCLES, 4, cycles between consecutive releases (>=1).
- CNT_W, derived, counter width = $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1); localparam, not overridable.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  request a reset sequence on the domains in req_mask.
- req_ready  output  1  high only in IDLE; handshake occurs when req_valid && req_ready at a clk edge.
- req_mask  input  NUM_DOMAINS  domains to reset; sampled at handshake.
- domain_rst  output  NUM_DOMAINS  registered active-high reset per domain.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a sequence completes.

Behaviour:
- States: IDLE, HOLD, GAP, DONE. Registers:
  - state;
  - pending[NUM_DOMAINS-1:0] (domains still to release);
  - cnt[CNT_W-1:0].
- rst sampled high at an edge:
  - domain_rst = all ones; pending = all ones;
  - state = HOLD; cnt = HOLD_CYCLES-1;
  - done = 0; req_ready = 0; busy = 1.
  - This applies from any state, including mid-sequence. The sequence restarts from the beginning, and all domains are re-asserted, even ones already released.
- Handshake at edge E0 in IDLE:
  - mask nonzero: domain_rst |= req_mask; pending = req_mask; state = HOLD; cnt = HOLD_CYCLES-1.
  - mask zero: state = DONE, with no domain_rst change.
- HOLD:
  - Each edge with cnt != 0 decrements cnt.
  - At the edge with cnt == 0, release the lowest set bit of pending: clear it in both domain_rst and pending.
  - If other pending bits remain: state = GAP, cnt = GAP_CYCLES-1. Otherwise state = DONE.
  - Resulting timing: first release at edge E0+HOLD_CYCLES. For the post-reset sequence, E0 is the last edge at which rst was sampled high.
- GAP: same countdown. Each further release occurs GAP_CYCLES edges after the previous one. Unselected indices are skipped with no extra gap.
- DONE:
  - done = 1 for exactly one cycle (the cycle following the final release edge).
  - busy = 1; req_ready = 0.
  - Next edge: state = IDLE.
- IDLE: busy = 0, req_ready = 1, done = 0. domain_rst holds its value; bits not in a mask are never touched.
- req_valid while not IDLE: ignored, no queuing. The requester must hold req_valid until it sees ready.
- domain_rst bits only go 1->0 in release order; no bit toggles combinationally. All outputs are registered except req_ready/busy, which decode state.
- Only domain_rst bits set in the current mask change during a sequence.

Decomposition:
- Shared package reset_seq_pkg:
  - state enum (IDLE, HOLD, GAP, DONE, 2 bits);
  - a function returning the one-hot lowest set bit of a vector (also reused by arbiters).
- One natural sub-module: reset_seq_counter. It is a loadable down-counter with a zero flag, with ports load, load_val and zero.
- The FSM and pending/domain_rst registers stay in reset_sequencer.

Test Plan:
1. Defaults, rst high for 3 edges then low.
   - Required: domain_rst=4'b1111 and busy=1 during and after rst.
   - Releases at Rlast+8 (bit0), +12 (bit1), +16 (bit2), +20 (bit3).
   - done=1 only in cycle after Rlast+20; req_ready=1 from Rlast+21.
2. In IDLE, handshake req_mask=4'b1010 at E0.
   - Required: bits 1 and 3 rise after E0; bits 0/2 stay 0.
   - bit1 falls at E0+8, bit3 at E0+12; done pulse after E0+12.
3. Handshake req_mask=4'b0000.
   - Required: domain_rst unchanged; done=1 in cycle after E0; IDLE again after E0+1.
4. req_valid held high with mask 4'b0001 during an active sequence.
   - Required: req_ready=0 and no effect until IDLE.
   - Then accepted on the first IDLE edge, and bit0 pulses for 8 cycles.
5. rst asserted at E0+10 during scenario 2.
   - Required: domain_rst=4'b1111 on the next edge and done never pulses for the aborted sequence.
   - Full post-reset sequence as in scenario 1.
6. HOLD_CYCLES=1, GAP_CYCLES=1, NUM_DOMAINS=2, mask 2'b11 at E0.
   - Required: bit0 falls at E0+1, bit1 at E0+2, done after E0+2.
